// File: rtl/spio_hss_multiplexer_pkt_store_v2_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spio_hss_multiplexer_pkt_store_v2_if                               |
// | Packet, ack/nak and frame-issue signals of the packet store        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface spio_hss_multiplexer_pkt_store_v2_if #(
    parameter int PKT_BITS = 72,
    parameter int SEQ_BITS = 7,
    parameter int BUF_BITS = 3,
    parameter int CNT_BITS = 16
);
    logic                empty;
    logic                full;
    logic [BUF_BITS:0]   occupancy;
    logic                flush;
    logic                cfc_rem;
    logic                vld_ack;
    logic                vld_nak;
    logic [SEQ_BITS-1:0] ack_seq;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_vld;
    logic                pkt_rdy;
    logic [SEQ_BITS-1:0] bpkt_seq;
    logic                bpkt_rq;
    logic [PKT_BITS-1:0] bpkt_data;
    logic                bpkt_pres;
    logic                bpkt_gt;
    logic                stale_err;
    logic [CNT_BITS-1:0] resend_cnt;

    modport master (
        output flush, cfc_rem, vld_ack, vld_nak, ack_seq, pkt_data, pkt_vld,
               bpkt_seq, bpkt_rq,
        input  empty, full, occupancy, pkt_rdy, bpkt_data, bpkt_pres, bpkt_gt,
               stale_err, resend_cnt
    );

    modport slave (
        input  flush, cfc_rem, vld_ack, vld_nak, ack_seq, pkt_data, pkt_vld,
               bpkt_seq, bpkt_rq,
        output empty, full, occupancy, pkt_rdy, bpkt_data, bpkt_pres, bpkt_gt,
               stale_err, resend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/spio_hss_multiplexer_pkt_store_v2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spio_hss_multiplexer_pkt_store_v2                                  |
// | Retransmission packet store with seq map, ack/nak rewind, flush    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module spio_hss_multiplexer_pkt_store_v2 #(
    parameter int PKT_BITS = 72,
    parameter int SEQ_BITS = 7,
    parameter int BUF_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    spio_hss_multiplexer_pkt_store_v2_if.slave bus
);
    localparam int               c_depth_n = 2 ** BUF_BITS;
    localparam logic [BUF_BITS:0] c_depth  = {1'b1, {BUF_BITS{1'b0}}};
    localparam logic [BUF_BITS:0] c_one    = {{BUF_BITS{1'b0}}, 1'b1};

    logic [BUF_BITS:0]   r_ba, r_br, r_bw;
    logic [PKT_BITS-1:0] r_mem [c_depth_n];
    logic [BUF_BITS:0]   r_map_ptr [c_depth_n];
    logic [c_depth_n-1:0] r_map_vld;

    logic                r_empty, r_full, r_pkt_rdy, r_gt, r_pres, r_stale;
    logic [BUF_BITS:0]   r_occ;
    logic [PKT_BITS-1:0] r_data;
    logic [CNT_BITS-1:0] r_cnt;

    logic                w_writing, w_reading;
    logic [BUF_BITS-1:0] w_idx;
    logic [BUF_BITS:0]   w_m_ptr, w_m_off, w_r_off, w_ack_tgt;
    logic                w_in_win, w_ack_cur, w_ack_ok, w_nak_ok, w_stale;
    logic [BUF_BITS:0]   w_nxt_ba, w_nxt_br, w_nxt_bw, w_nxt_occ;

    assign w_writing = bus.pkt_vld & r_pkt_rdy;
    assign w_reading = bus.bpkt_rq & ~r_empty & bus.cfc_rem & ~bus.flush;

    // Window test is done on offsets from ba so it survives pointer wrap.
    assign w_idx     = bus.ack_seq[BUF_BITS-1:0];
    assign w_m_ptr   = r_map_ptr[w_idx];
    assign w_m_off   = w_m_ptr - r_ba;
    assign w_r_off   = r_br - r_ba;
    assign w_in_win  = r_map_vld[w_idx] & (w_m_off <= w_r_off);
    assign w_ack_cur = (bus.ack_seq == bus.bpkt_seq);
    assign w_ack_tgt = w_ack_cur ? r_br : w_m_ptr;
    assign w_ack_ok  = bus.vld_ack & (w_ack_cur | w_in_win);
    assign w_nak_ok  = bus.vld_nak & w_in_win;
    assign w_stale   = ~bus.flush & ((bus.vld_ack & ~(w_ack_cur | w_in_win)) |
                                     (bus.vld_nak & ~w_in_win));

    always_comb begin
        w_nxt_bw = r_bw + (w_writing ? c_one : '0);
        w_nxt_br = r_br;
        w_nxt_ba = r_ba;
        if (bus.flush) begin
            w_nxt_ba = r_bw;
            w_nxt_br = r_bw;
        end else begin
            if (w_reading) begin
                w_nxt_br = r_br + c_one;
            end
            if (w_nak_ok) begin
                w_nxt_br = w_m_ptr;
                w_nxt_ba = w_m_ptr;
            end
            // With a simultaneous nak, ba keeps whichever target is later.
            if (w_ack_ok && (!w_nak_ok || ((w_ack_tgt - r_ba) > w_m_off))) begin
                w_nxt_ba = w_ack_tgt;
            end
        end
        w_nxt_occ = w_nxt_bw - w_nxt_ba;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ba      <= '0;
            r_br      <= '0;
            r_bw      <= '0;
            r_map_vld <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_occ     <= '0;
            r_pkt_rdy <= 1'b0;
            r_gt      <= 1'b0;
            r_pres    <= 1'b0;
            r_data    <= '0;
            r_stale   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ba      <= w_nxt_ba;
            r_br      <= w_nxt_br;
            r_bw      <= w_nxt_bw;
            r_empty   <= (w_nxt_br == w_nxt_bw);
            r_full    <= (w_nxt_occ == c_depth);
            r_occ     <= w_nxt_occ;
            r_pkt_rdy <= (w_nxt_occ != c_depth);
            r_gt      <= w_reading;
            r_stale   <= w_stale;
            if (w_reading) begin
                r_data <= r_mem[r_br[BUF_BITS-1:0]];
            end
            if (bus.bpkt_rq) begin
                r_pres <= w_reading;
            end
            if (bus.flush) begin
                r_map_vld <= '0;
            end else if (bus.bpkt_rq) begin
                r_map_vld[bus.bpkt_seq[BUF_BITS-1:0]] <= 1'b1;
            end
            if (!bus.flush && w_nak_ok && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_writing) begin
            r_mem[r_bw[BUF_BITS-1:0]] <= bus.pkt_data;
        end
        if (bus.bpkt_rq) begin
            r_map_ptr[bus.bpkt_seq[BUF_BITS-1:0]] <= r_br;
        end
    end

    assign bus.empty      = r_empty;
    assign bus.full       = r_full;
    assign bus.occupancy  = r_occ;
    assign bus.pkt_rdy    = r_pkt_rdy;
    assign bus.bpkt_data  = r_data;
    assign bus.bpkt_pres  = r_pres;
    assign bus.bpkt_gt    = r_gt;
    assign bus.stale_err  = r_stale;
    assign bus.resend_cnt = r_cnt;
endmodule
`default_nettype wire
